// File: rtl/pwm_pkg.sv
// Shared types and default constants for the sine PWM modulator slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: output FSM state enum, default sample width / dead time,
// PWM period length derived from the default width.
package pwm_pkg;

   localparam int DEF_DATA_W = 10;
   localparam int DEF_DEAD_T = 4;
   localparam int PERIOD     = 2 ** DEF_DATA_W;

   typedef enum logic [2:0] {
      OFF,
      HI_ON,
      DT_HI,
      LO_ON,
      DT_LO
   } pwm_state_t;

endpackage

// File: rtl/pwm_deadtime_gen.sv
// Complementary half-bridge drive with dead-time insertion from a raw PWM level.
// Latency: outputs registered, 1 clock behind raw; each raw edge adds DEAD_T clocks off-time.
// Backpressure: none; raw pulses shorter than DEAD_T are swallowed.
//
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   enable       : low forces OFF (both outputs low)
//   raw          : desired high-side level, already aligned to the period counter
//   pwm_hi/lo    : registered high-side / low-side drive, never both high
module pwm_deadtime_gen
   import pwm_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEAD_T = DEF_DEAD_T
) (
   input  logic clock,
   input  logic reset,
   input  logic enable,
   input  logic raw,
   output logic pwm_hi,
   output logic pwm_lo
);

   // Dead time is at most 2^(DATA_W-1)-1, so DATA_W-1 bits always suffice.
   localparam int DW = DATA_W - 1;

   pwm_state_t    state;
   logic [DW-1:0] dead_cnt;

   // Outputs are assigned from the next state so they line up with it.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= OFF;
         dead_cnt <= '0;
         pwm_hi   <= 1'b0;
         pwm_lo   <= 1'b0;
      end else if (!enable) begin
         state    <= OFF;
         dead_cnt <= '0;
         pwm_hi   <= 1'b0;
         pwm_lo   <= 1'b0;
      end else begin
         case (state)
            OFF: begin
               state    <= raw ? DT_HI : DT_LO;
               dead_cnt <= '0;
               pwm_hi   <= 1'b0;
               pwm_lo   <= 1'b0;
            end
            HI_ON: begin
               pwm_lo <= 1'b0;
               if (!raw) begin
                  state    <= DT_LO;
                  dead_cnt <= '0;
                  pwm_hi   <= 1'b0;
               end else begin
                  pwm_hi <= 1'b1;
               end
            end
            LO_ON: begin
               pwm_hi <= 1'b0;
               if (raw) begin
                  state    <= DT_HI;
                  dead_cnt <= '0;
                  pwm_lo   <= 1'b0;
               end else begin
                  pwm_lo <= 1'b1;
               end
            end
            DT_HI, DT_LO: begin
               // The side chosen at the end of dead time follows the current
               // raw level, not the one that started the dead time.
               if (dead_cnt == DW'(DEAD_T - 1)) begin
                  state  <= raw ? HI_ON : LO_ON;
                  pwm_hi <= raw;
                  pwm_lo <= !raw;
               end else begin
                  dead_cnt <= dead_cnt + 1'b1;
                  pwm_hi   <= 1'b0;
                  pwm_lo   <= 1'b0;
               end
            end
            default: begin
               state    <= OFF;
               dead_cnt <= '0;
               pwm_hi   <= 1'b0;
               pwm_lo   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/sine_pwm_modulator.sv
// Edge-aligned PWM modulator: turns sine samples into duty cycles with dead-time drive.
// Latency: sample taken in period P drives period P+1; outputs lag the period counter by 2 clocks.
// Backpressure: none; samples always accepted, an unconsumed sample is overwritten (overrun).
//
// Ports:
//   clock, reset   : system clock, synchronous active-high reset
//   enable         : run; low forces outputs off, clears pending, keeps duty_q
//   data_sin       : unsigned sample, qualified by sample_valid
//   pwm_hi/pwm_lo  : complementary drive
//   period_start   : pulse aligned with the first raw level of each period
//   duty_q         : duty in effect for the current period
//   overrun        : pending sample overwritten before it was used
//   underrun       : period began without a new sample, duty repeated
module sine_pwm_modulator
   import pwm_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEAD_T = DEF_DEAD_T
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic [DATA_W-1:0] data_sin,
   input  logic              sample_valid,
   output logic              pwm_hi,
   output logic              pwm_lo,
   output logic              period_start,
   output logic [DATA_W-1:0] duty_q,
   output logic              overrun,
   output logic              underrun
);

   logic [DATA_W-1:0] cnt;
   logic [DATA_W-1:0] pending;
   logic              pending_full;
   logic              enable_d;
   logic              raw_q;

   logic              load;
   logic              take;
   logic [DATA_W-1:0] duty_next;

   assign load      = enable && (cnt == '0);
   assign take      = load && pending_full;
   assign duty_next = take ? pending : duty_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt          <= '0;
         pending      <= '0;
         pending_full <= 1'b0;
         enable_d     <= 1'b0;
         raw_q        <= 1'b0;
         duty_q       <= '0;
         period_start <= 1'b0;
         overrun      <= 1'b0;
         underrun     <= 1'b0;
      end else begin
         enable_d     <= enable;
         cnt          <= enable ? cnt + 1'b1 : '0;
         duty_q       <= duty_next;
         period_start <= load;
         // Compare against the duty after any load so the new duty governs
         // cnt==0 as well; raw_q is registered alongside period_start.
         raw_q        <= enable && (cnt < duty_next);
         // enable_d low marks the first period after enable rises.
         underrun     <= load && !pending_full && enable_d;
         overrun      <= enable && sample_valid && pending_full && !load;

         if (!enable) begin
            pending_full <= 1'b0;
         end else if (sample_valid) begin
            // On a load cycle the old pending is taken first, so the new
            // sample simply becomes the next pending entry.
            pending      <= data_sin;
            pending_full <= 1'b1;
         end else if (take) begin
            pending_full <= 1'b0;
         end
      end
   end

   pwm_deadtime_gen #(
      .DATA_W (DATA_W),
      .DEAD_T (DEAD_T)
   ) u_deadtime (
      .clock  (clock),
      .reset  (reset),
      .enable (enable),
      .raw    (raw_q),
      .pwm_hi (pwm_hi),
      .pwm_lo (pwm_lo)
   );

endmodule

// File: tb/tb_sine_pwm_modulator.sv
// Scoreboard bench for sine_pwm_modulator: period-level reference model vs DUT.
// Latency: expectations for a period are queued at its load cycle, checked at period_start.
// Backpressure: none; monitor runs free on the falling clock edge.
module tb_sine_pwm_modulator;
   import pwm_pkg::*;

   localparam int P  = PERIOD;
   localparam int DT = DEF_DEAD_T;

   logic       clock;
   logic       reset;
   logic       enable;
   logic [9:0] data_sin;
   logic       sample_valid;
   logic       pwm_hi;
   logic       pwm_lo;
   logic       period_start;
   logic [9:0] duty_q;
   logic       overrun;
   logic       underrun;

   sine_pwm_modulator dut (
      .clock        (clock),
      .reset        (reset),
      .enable       (enable),
      .data_sin     (data_sin),
      .sample_valid (sample_valid),
      .pwm_hi       (pwm_hi),
      .pwm_lo       (pwm_lo),
      .period_start (period_start),
      .duty_q       (duty_q),
      .overrun      (overrun),
      .underrun     (underrun)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      int duty;
      bit under;
      int over;
      bit chk;
      int hi;
      int lo;
   } rec_t;

   rec_t q[$];
   int total = 0;
   int bad   = 0;

   task automatic check(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Expected high-time of each output over one period of raw with duty d.
   // lo_start: the previous period ended with the low side fully on.
   function automatic void exp_counts(input int d, input bit lo_start,
                                      output int h, output int l);
      if (d == 0) begin
         h = 0; l = P;
      end else if (d <= DT) begin
         h = 0; l = P - DT;
      end else if (d >= P - DT) begin
         l = 0; h = lo_start ? d - DT : P - DT;
      end else begin
         h = d - DT; l = P - d - DT;
      end
   endfunction

   // Reference model state (stimulus process only).
   int cnt_m  = 0;   // period counter value in the current cycle
   int duty_m = 0;   // duty of the current period
   int dprev  = 0;   // duty of the period before it
   int k      = 0;   // samples seen in the current period
   int last_v = 0;   // most recent sample in the current period
   int psince = 0;   // periods begun since enable rose

   task automatic tick(input bit v, input int d);
      rec_t r;
      sample_valid = v;
      data_sin     = 10'(d);
      if (reset) begin
         duty_m = 0; k = 0; psince = 0;
      end else if (!enable) begin
         k = 0; psince = 0;
      end else begin
         if (cnt_m == 0) begin
            r.duty  = (k > 0) ? last_v : duty_m;
            r.under = (k == 0) && (psince > 0);
            r.over  = (k > 1) ? k - 1 : 0;
            r.chk   = (psince >= 2) && ((dprev <= P - DT - 1) || (dprev == duty_m));
            exp_counts(duty_m, dprev <= P - DT - 1, r.hi, r.lo);
            q.push_back(r);
            dprev  = duty_m;
            duty_m = r.duty;
            psince++;
            k = 0;
         end
         if (v) begin
            k++;
            last_v = d;
         end
      end
      @(posedge clock);
      #1;
      cnt_m = (reset || !enable) ? 0 : (cnt_m + 1) % P;
   endtask

   task automatic run_period(input int ns, input int pa, input int va,
                             input int pb, input int vb);
      for (int c = 0; c < P; c++) begin
         if (ns > 1 && c == pb)      tick(1'b1, vb);
         else if (ns > 0 && c == pa) tick(1'b1, va);
         else                        tick(1'b0, 0);
      end
   endtask

   task automatic run_part(input int n, input int pa, input int va);
      for (int c = 0; c < n; c++) begin
         if (c == pa) tick(1'b1, va);
         else         tick(1'b0, 0);
      end
   endtask

   function automatic int pick_val();
      int sel;
      sel = int'($urandom_range(0, 9));
      case (sel)
         0:       return 0;
         1:       return int'($urandom_range(1, DT + 1));
         2:       return int'($urandom_range(P - DT - 2, P - 1));
         default: return int'($urandom_range(0, P - 1));
      endcase
   endfunction

   // Monitor: per-period accumulation, compared at each period_start.
   int hi_acc = 0, lo_acc = 0, ov_acc = 0, both = 0, stray_un = 0;
   initial begin
      rec_t r;
      forever begin
         @(negedge clock);
         if (pwm_hi && pwm_lo) both++;
         if (reset || !enable) begin
            hi_acc = 0; lo_acc = 0; ov_acc = 0;
         end else begin
            hi_acc += int'(pwm_hi);
            lo_acc += int'(pwm_lo);
            if (period_start) begin
               if (q.size() == 0) begin
                  check("sb_empty_at_period_start", 1, 0);
               end else begin
                  r = q.pop_front();
                  check("duty_q", int'(duty_q), r.duty);
                  check("underrun", int'(underrun), int'(r.under));
                  check("overrun_count", ov_acc, r.over);
                  if (r.chk) begin
                     check("hi_clocks", hi_acc, r.hi);
                     check("lo_clocks", lo_acc, r.lo);
                  end
               end
               hi_acc = 0; lo_acc = 0; ov_acc = 0;
            end else if (underrun) begin
               stray_un++;
            end
            ov_acc += int'(overrun);
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1);
   end

   initial begin
      reset = 1'b1; enable = 1'b0; sample_valid = 1'b0; data_sin = '0;
      tick(1'b0, 0);
      tick(1'b0, 0);
      check("rst_hi", int'(pwm_hi), 0);
      check("rst_lo", int'(pwm_lo), 0);
      check("rst_duty", int'(duty_q), 0);
      check("rst_pstart", int'(period_start), 0);
      check("rst_over", int'(overrun), 0);
      check("rst_under", int'(underrun), 0);
      reset = 1'b0;
      tick(1'b0, 0);
      check("off_hi", int'(pwm_hi), 0);
      check("off_pstart", int'(period_start), 0);

      enable = 1'b1;
      run_period(1, 500, 512, 0, 0);     // P1: sample 512 before first wrap
      run_period(1, 100, 0, 0, 0);       // P2: duty 512
      run_period(1, 900, 1023, 0, 0);    // P3: duty 0
      run_period(1, 3, 1023, 0, 0);      // P4: duty 1023
      run_period(1, P - 1, 2, 0, 0);     // P5: duty 1023 steady
      run_period(1, 0, 2, 0, 0);         // P6: duty 2, sample on load cycle
      run_period(2, 200, 100, 600, 700); // P7: duty 2, overrun
      run_period(0, 0, 0, 0, 0);         // P8: duty 700
      run_period(1, 10, 300, 0, 0);      // P9: underrun, duty 700
      run_period(1, 0, 800, 0, 0);       // P10: duty 300, 800 pending
      run_period(0, 0, 0, 0, 0);         // P11: duty 800

      for (int i = 0; i < 20; i++) begin
         run_period(int'($urandom_range(0, 2)),
                    int'($urandom_range(0, P - 1)), pick_val(),
                    int'($urandom_range(0, P - 1)), pick_val());
      end

      run_period(1, 50, 700, 0, 0);
      run_part(300, 250, 123);           // duty 700, mid high-side on
      check("hi_before_drop", int'(pwm_hi), 1);
      enable = 1'b0;
      tick(1'b0, 0);
      check("drop_hi", int'(pwm_hi), 0);
      check("drop_lo", int'(pwm_lo), 0);
      for (int i = 0; i < 4; i++) tick(1'b0, 0);
      check("drop_pstart", int'(period_start), 0);
      check("drop_duty_kept", int'(duty_q), 700);

      enable = 1'b1;
      run_period(0, 0, 0, 0, 0);         // first period: duty kept, no underrun
      run_period(1, 20, 900, 0, 0);
      run_part(400, 1000, 0);
      reset = 1'b1;
      tick(1'b0, 0);
      check("mid_rst_hi", int'(pwm_hi), 0);
      check("mid_rst_lo", int'(pwm_lo), 0);
      check("mid_rst_duty", int'(duty_q), 0);
      check("mid_rst_pstart", int'(period_start), 0);
      reset = 1'b0;
      run_period(1, 5, 640, 0, 0);
      run_period(0, 0, 0, 0, 0);
      run_period(0, 0, 0, 0, 0);
      enable = 1'b0;
      for (int i = 0; i < 3; i++) tick(1'b0, 0);

      check("sb_left_over", q.size(), 0);
      check("hi_and_lo_overlap", both, 0);
      check("stray_underrun", stray_un, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
